// File: rtl/line_memory.sv
// line_memory: line-wide main-memory responder; fixed LATENCY-cycle access, one-cycle rdy pulse, busy while not IDLE.
// Optional LINE_MEMORY_CLEAR_EN: zero every line after reset (INIT) before the first request is accepted.
module line_memory #(
  parameter int ADDR_W  = 14,
  parameter int LINE_W  = 64,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              rdy,
  output logic              busy
);

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              op_wr;
  logic              accept;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [LINE_W-1:0] mem_wdat;
  logic [LINE_W-1:0] mem [2**ADDR_W];

`ifdef LINE_MEMORY_CLEAR_EN
  localparam state_t RST_STATE = INIT;
  logic [ADDR_W-1:0] clr_ptr;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdat  = wdata_q;
    case (state)
      IDLE: begin
        if (re | we) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // the array access happens on the edge that leaves WAIT
        if (cnt == 4'd0) begin
          done    = 1'b1;
          mem_we  = op_wr;
          state_d = RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: begin
`ifdef LINE_MEMORY_CLEAR_EN
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdat  = '0;
        if (clr_ptr == '1) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr   <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        op_wr   <= we;
      end
      if (done && !op_wr) rdata <= mem[addr_q];
    end
  end

`ifdef LINE_MEMORY_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              clr_ptr <= '0;
    else if (state == INIT)  clr_ptr <= clr_ptr + 1'b1;
  end
`endif

  // array has no reset; contents are either cleared in INIT or left undefined
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
  end

  assign rdy  = (state == RESP);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_line_memory.sv
// Randomized scoreboard bench for line_memory (ADDR_W=4, LATENCY=4); honours LINE_MEMORY_CLEAR_EN if defined.
module tb_line_memory;
  localparam int AW  = 4;
  localparam int LAT = 4;
  localparam int NL  = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          re, we;
  logic [63:0]   wdata;
  logic [63:0]   rdata;
  logic          rdy, busy;

  line_memory #(.ADDR_W(AW), .LINE_W(64), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we),
    .wdata(wdata), .rdata(rdata), .rdy(rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [63:0] mdl [NL];
  bit          vld [NL];
  logic [63:0] last_rd;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every rdy pulse must match the oldest outstanding transaction
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdy) begin
        if (q.size() == 0) begin
          check("unexpected_rdy", 64'(rdy), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("rdy_cycle", 64'(cyc), 64'(mon_e.cyc));
          check(mon_e.is_rd ? "read_data" : "write_keeps_rdata", rdata, mon_e.data);
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        check("rdy_missing", 64'(rdy), 64'd1);
        void'(q.pop_front());
      end
    end
  end

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(bit r, bit w, logic [AW-1:0] a, logic [63:0] d);
    exp_t e;
    int   n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("issue_timeout", 64'(busy), 64'd0);
    re = r; we = w; addr = a; wdata = d;
    if (w) begin
      mdl[a] = d;
      vld[a] = 1'b1;
      e.is_rd = 1'b0;
      e.data  = last_rd;
    end else begin
      e.is_rd = 1'b1;
      e.data  = mdl[a];
      last_rd = mdl[a];
    end
    e.cyc = cyc + 1 + LAT;
    q.push_back(e);
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    addr = AW'($urandom_range(0, NL-1));
    wdata = {$urandom, $urandom};
  endtask

  task automatic wait_clear();
`ifdef LINE_MEMORY_CLEAR_EN
    int n = 0;
    re = 1'b1; we = 1'b1; addr = '0; wdata = '1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    re = 1'b0; we = 1'b0;
    check("init_busy_cycles", 64'(n), 64'(NL));
    for (int i = 0; i < NL; i++) begin
      mdl[i] = '0;
      vld[i] = 1'b1;
    end
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    logic [63:0] old;
    bit          exp_busy_rst;
`ifdef LINE_MEMORY_CLEAR_EN
    exp_busy_rst = 1'b1;
`else
    exp_busy_rst = 1'b0;
`endif
    for (int i = 0; i < NL; i++) begin
      mdl[i] = '0;
      vld[i] = 1'b0;
    end
    rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; last_rd = '0;
    repeat (2) @(negedge clk);
    check("reset_rdy", 64'(rdy), 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_busy", 64'(busy), 64'(exp_busy_rst));
    rst_n = 1'b1;
    wait_clear();
`ifdef LINE_MEMORY_CLEAR_EN
    issue(1'b1, 1'b0, 4'd0, '0);
    issue(1'b1, 1'b0, 4'd15, '0);
`endif

    issue(1'b0, 1'b1, 4'd5, 64'h1111_2222_3333_4444);
    issue(1'b1, 1'b0, 4'd5, '0);

    // write attempt while the read is still in WAIT must be dropped
    issue(1'b1, 1'b0, 4'd5, '0);
    check("busy_in_wait", 64'(busy), 64'd1);
    we = 1'b1; addr = 4'd5; wdata = 64'hDEAD;
    @(negedge clk);
    we = 1'b0;
    issue(1'b1, 1'b0, 4'd5, '0);

    issue(1'b1, 1'b1, 4'd9, 64'hABCD);
    issue(1'b1, 1'b0, 4'd9, '0);

    issue(1'b0, 1'b1, 4'd0, 64'h0F0F_0F0F);
    issue(1'b0, 1'b1, 4'd15, 64'h5A5A);
    issue(1'b1, 1'b0, 4'd15, '0);
    issue(1'b1, 1'b0, 4'd0, '0);

    // reset during a pending write: nothing commits, no rdy
    issue(1'b0, 1'b1, 4'd3, 64'h0101);
    old = mdl[3];
    issue(1'b0, 1'b1, 4'd3, 64'hFFFF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    mdl[3] = old;
    @(negedge clk);
    check("midreset_rdy", 64'(rdy), 64'd0);
    check("midreset_busy", 64'(busy), 64'(exp_busy_rst));
    check("midreset_rdata", rdata, 64'd0);
    last_rd = '0;
    repeat (LAT + 2) @(negedge clk);
    rst_n = 1'b1;
    wait_clear();
    issue(1'b1, 1'b0, 4'd3, '0);

    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, NL-1));
      if ($urandom_range(0, 2) == 0 || !vld[a])
        issue(1'($urandom_range(0, 1)), 1'b1, a, {$urandom, $urandom});
      else
        issue(1'b1, 1'b0, a, {$urandom, $urandom});
    end

    repeat (LAT + 4) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_memory.md
# line_memory

Multi-cycle, line-wide main-memory responder at the far end of the cache-to-memory interface. It accepts one line read or line write per transaction from the cache controller, models a fixed access latency with an internal counter, and signals completion with a one-cycle `rdy` pulse. It is the memory side of the protocol that the instruction/data cache controller initiates.

## Interface
Parameters:
- `ADDR_W`, 14: line-address width; the array holds 2^ADDR_W lines.
- `LINE_W`, 64: line width in bits (four 16-bit words).
- `LATENCY`, 4: cycles from request acceptance to `rdy`; legal range 1..15.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `addr`  in  ADDR_W  line address of the request.
- `re`  in  1  read request.
- `we`  in  1  write request.
- `wdata`  in  LINE_W  write line.
- `rdata`  out  LINE_W  read line; valid while `rdy`=1.
- `rdy`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever a new request would not be accepted.

## Operation
- States: INIT (only with the macro), IDLE, WAIT, RESP.
- IDLE: at a rising edge where `re`|`we`=1, the block latches `addr`, `wdata`, and the op. The op is write if `we`=1 (write wins over `re`), otherwise read. It loads the counter with LATENCY-1 and goes to WAIT.
- WAIT: the counter decrements each edge. At the edge where the counter is 0, the state goes to RESP.
  - A read loads `rdata` from the array at that edge.
  - A write commits the latched `wdata` to the array at that edge.
- RESP: `rdy`=1 for exactly this one cycle. The next edge always returns to IDLE. Requests are not accepted in RESP.
- WAIT/RESP: `re`/`we`/`addr`/`wdata` are ignored. The requester does not have to hold them after acceptance.
- `busy` = (state != IDLE).
- `rdata` holds the last completed read value until the next read completes. Writes do not change `rdata`.
- Write then read of the same address returns the new data. There is no forwarding issue because transactions are serialized.
- Address arithmetic: no wrap logic. `addr` indexes the array directly, and all 2^ADDR_W values are legal.

## Timing
- Request accepted at edge k: `rdy` is high during the cycle after edge k+LATENCY.
- Next acceptance is possible at edge k+LATENCY+2 at the earliest.
- LATENCY=1: WAIT lasts one cycle, and `rdy` is high in the cycle after edge k+1.
- Reset values:
  - `rdy`=0, `rdata`=0, counter=0.
  - State is IDLE (`busy`=0) without the macro, INIT (`busy`=1) with it.
- Reset asserted mid-transaction: the transaction is abandoned and a pending write is not committed. No `rdy` pulse occurs for it.
- `re`=`we`=1 in IDLE: the block performs a write. `rdata` is unchanged.

## Configuration
- Macro `LINE_MEMORY_CLEAR_EN`, defined:
  - After reset the block enters INIT and writes zero to one line per cycle, from line 0 to line 2^ADDR_W-1, using a clear pointer.
  - It enters IDLE at the edge after the last line is written. `busy`=1 and requests are ignored throughout INIT.
  - Reset during INIT restarts the clear from line 0.
- Macro undefined:
  - There is no INIT state, and the array contents after reset are undefined (X in simulation).
  - The block is in IDLE immediately after reset deassertion.

## Test plan
- Read latency, LATENCY=4: write 64'h1111_2222_3333_4444 to addr 5, then read addr 5 accepted at edge k -> `rdy` high only in the cycle after edge k+4, `rdata`=64'h1111_2222_3333_4444.
- Request during busy: accept read of addr 5, then pulse `we` with addr 5 and 64'hDEAD while in WAIT -> ignored; a later read of addr 5 still returns 64'h1111_2222_3333_4444.
- Simultaneous `re`&`we` in IDLE, addr 9, wdata 64'hABCD -> write performed, `rdata` unchanged at the `rdy` pulse, a later read of addr 9 returns 64'hABCD.
- Reset mid-write: accept write of 64'hFFFF to addr 3 (prior value 64'h0101), assert `rst_n`=0 during WAIT -> `rdy`=0, `busy` follows the reset values, a read of addr 3 returns 64'h0101 (macro off) or 0 (macro on).
- Boundary address plus LATENCY=1: write, then read, addr 2^ADDR_W-1 with 64'h5A5A -> `rdy` 2 cycles after acceptance, data returned intact, addr 0 unaffected.
- With `LINE_MEMORY_CLEAR_EN`, ADDR_W=4: after reset `busy`=1 for exactly 16 cycles and requests are ignored; then reads of addr 0 and addr 15 return 0.
